adc_spi_reader: RTL
===================

# adc_spi_reader

SPI master front-end that periodically reads an external serial ADC and presents each conversion as a parallel word on `adcdata`, the CPU's ADC input port. It drives SPI mode 0 (`sclk` idle low, `miso` sampled on the rising edge, MSB first). It zero-extends each sample to `DWIDTH` and holds it stable until the next conversion completes, so the CPU can read `adcdata` at any time.

## Interface
- `DWIDTH`, 32, width of `adcdata`; must satisfy `SAMPLEBITS <= DWIDTH`.
- `SAMPLEBITS`, 12, ADC resolution (bits shifted per conversion); range 1..`DWIDTH`.
- `CLKDIV`, 4, `clock` cycles per `sclk` half-period; must be ≥1.
- `CONVGAP`, 8, `clock` cycles `csn` stays high between back-to-back conversions; must be ≥1.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; while high, conversions repeat continuously.
- `miso`  in  1  serial data from the ADC.
- `sclk`  out  1  SPI clock, registered.
- `csn`  out  1  ADC chip select, active low, registered.
- `adcdata`  out  `DWIDTH`  last completed sample, zero-extended, registered.
- `valid`  out  1  one-cycle pulse when `adcdata` updates.
- `busy`  out  1  high while `csn` is low.

## Operation
- Reset values: `sclk`=0, `csn`=1, `adcdata`=0, `valid`=0, `busy`=0, state IDLE, all counters 0.
- Three states: IDLE, SHIFT, GAP.
- IDLE → SHIFT:
  - Taken on the first edge where `enable`=1.
  - On that edge: `csn`←0, `busy`←1, half-period counter `hcnt`←0, divider `dcnt`←0.
- SHIFT:
  - `dcnt` counts 0..`CLKDIV`-1.
  - On the edge where `dcnt`=`CLKDIV`-1: `dcnt`←0, `sclk` toggles, `hcnt` increments.
  - On each edge that drives `sclk` 0→1, the current `miso` shifts into the shift register LSB; the register shifts left.
  - Total half-periods: 2·`SAMPLEBITS`.
- SHIFT → GAP:
  - Taken on the edge that drives `sclk` low after the last bit (`hcnt`=2·`SAMPLEBITS`-1 and `dcnt`=`CLKDIV`-1).
  - On that edge: `csn`←1, `busy`←0, `adcdata`←{zeros, shift register}, `valid`←1, gap counter `gcnt`←0.
- GAP:
  - `valid` returns to 0 after one cycle.
  - `gcnt` counts to `CONVGAP`-1.
  - On that edge: if `enable`=1, go to SHIFT with the same actions as IDLE→SHIFT; else go to IDLE.
- `enable` is ignored in SHIFT and in GAP before its last cycle. A conversion, once started, always completes and updates `adcdata`.
- `adcdata` changes only on the `valid` edge or at reset.

## Timing
- `csn` falls one edge after `enable` is first sampled high in IDLE.
- First `sclk` rise occurs `CLKDIV` cycles after `csn` falls; subsequent rises follow every 2·`CLKDIV` cycles.
- `csn` is low for exactly 2·`SAMPLEBITS`·`CLKDIV` cycles (96 at defaults).
- `valid` pulse and `adcdata` update occur on the same edge as `csn` rising.
- With `enable` held high, `csn` stays high exactly `CONVGAP` cycles, so the conversion period is 2·`SAMPLEBITS`·`CLKDIV`+`CONVGAP` (104 at defaults).
- ADC and bench change `miso` only while `sclk` is low. `miso` is sampled directly, with no synchronizer.
- Reset asserted mid-conversion: all outputs take their reset values immediately and asynchronously, and the partial sample is discarded. Operation restarts from IDLE after reset deasserts.

## Structure
- Package `adc_pkg`: state enum typedef (IDLE, SHIFT, GAP) and default parameter constants.
- One sub-module, `spi_clkdiv`:
  - Inputs: `clock`, `reset`, `run`.
  - Outputs: `tick` (high on the `dcnt`=`CLKDIV`-1 edge); `dcnt` clears while `run`=0.
- The FSM, shift register and counters live in the top module.

## Test plan
- Single conversion, defaults, ADC model drives 12'hA5C MSB-first:
  - `csn` low for 96 cycles with 12 `sclk` pulses.
  - `adcdata`=32'h00000A5C; `valid` high exactly one cycle, on the edge `csn` rises.
- `enable` held, incrementing samples 1, 2, 3:
  - `valid` pulses 104 cycles apart.
  - `adcdata` reads 1, 2, 3; `csn` high exactly 8 cycles between conversions.
- `enable` dropped 10 cycles into a conversion with sample 12'hFFF:
  - Conversion completes; `adcdata`=32'h00000FFF.
  - After the 8-cycle GAP, returns to IDLE; no further `csn` fall.
- Reset asserted 40 cycles into a conversion:
  - `csn`=1, `sclk`=0, `adcdata`=0, `busy`=0 immediately, without waiting for a clock edge.
  - After release with `enable`=1, a full fresh conversion of 12'h123 yields 32'h00000123.
- Parameters `CLKDIV`=1, `SAMPLEBITS`=32, `CONVGAP`=1, sample 32'h80000001:
  - `csn` low 64 cycles; `adcdata`=32'h80000001; period 65 cycles.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and default parameters for the serial ADC reader.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int DEF_DWIDTH     = 32;
   localparam int DEF_SAMPLEBITS = 12;
   localparam int DEF_CLKDIV     = 4;
   localparam int DEF_CONVGAP    = 8;

   // bits needed for a counter running 0..n-1, never less than one
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Divider producing one tick every CLKDIV clocks while run is high; held cleared otherwise.
module spi_clkdiv
   import adc_pkg::*;
#(
   parameter int CLKDIV = DEF_CLKDIV
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int W = cnt_width(CLKDIV);

   logic [W-1:0] dcnt;

   assign tick = run && (dcnt == W'(CLKDIV - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dcnt <= '0;
      end else if (!run || tick) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + W'(1);
      end
   end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master that repeatedly reads a serial ADC and holds the last sample on adcdata.
//
//   state | meaning
//   IDLE  | csn high, waiting for enable
//   SHIFT | csn low, 2*SAMPLEBITS sclk half-periods, miso captured on sclk rise
//   GAP   | csn high for CONVGAP cycles; restart or drop to IDLE on the last one
module adc_spi_reader
   import adc_pkg::*;
#(
   parameter int DWIDTH     = DEF_DWIDTH,
   parameter int SAMPLEBITS = DEF_SAMPLEBITS,
   parameter int CLKDIV     = DEF_CLKDIV,
   parameter int CONVGAP    = DEF_CONVGAP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              miso,
   output logic              sclk,
   output logic              csn,
   output logic [DWIDTH-1:0] adcdata,
   output logic              valid,
   output logic              busy
);

   generate
      if (SAMPLEBITS < 1 || SAMPLEBITS > DWIDTH) begin : g_bad_samplebits
         $error("adc_spi_reader: SAMPLEBITS must be within 1..DWIDTH");
      end
      if (CLKDIV < 1 || CONVGAP < 1) begin : g_bad_timing
         $error("adc_spi_reader: CLKDIV and CONVGAP must be at least 1");
      end
   endgenerate

   localparam int HW = cnt_width(2 * SAMPLEBITS);
   localparam int GW = cnt_width(CONVGAP);

   state_t               state;
   logic [HW-1:0]        hcnt;
   logic [GW-1:0]        gcnt;
   logic [SAMPLEBITS-1:0] shreg;
   logic                 run;
   logic                 tick;
   logic                 last_half;
   logic                 gap_done;

   assign run       = (state == SHIFT);
   assign last_half = (hcnt == HW'(2 * SAMPLEBITS - 1));
   assign gap_done  = (gcnt == GW'(CONVGAP - 1));

   spi_clkdiv #(
      .CLKDIV (CLKDIV)
   ) u_clkdiv (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .tick  (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sclk    <= 1'b0;
         csn     <= 1'b1;
         busy    <= 1'b0;
         valid   <= 1'b0;
         adcdata <= '0;
         shreg   <= '0;
         hcnt    <= '0;
         gcnt    <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state <= SHIFT;
                  csn   <= 1'b0;
                  busy  <= 1'b1;
                  hcnt  <= '0;
               end
            end
            SHIFT: begin
               if (tick) begin
                  sclk <= ~sclk;
                  hcnt <= hcnt + HW'(1);
                  // capture on the edge that takes sclk high
                  if (!sclk) begin
                     shreg <= SAMPLEBITS'({shreg, miso});
                  end
                  if (last_half) begin
                     state   <= GAP;
                     csn     <= 1'b1;
                     busy    <= 1'b0;
                     adcdata <= DWIDTH'(shreg);
                     valid   <= 1'b1;
                     gcnt    <= '0;
                  end
               end
            end
            GAP: begin
               gcnt <= gcnt + GW'(1);
               if (gap_done) begin
                  if (enable) begin
                     state <= SHIFT;
                     csn   <= 1'b0;
                     busy  <= 1'b1;
                     hcnt  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
